mips_muldiv_unit: RTL and testbench
===================================

Name: mips_muldiv_unit

Overview:
- Parametrised, iterative multi-cycle multiply/divide unit with HI/LO registers for the MIPS core.
- Replaces the single-cycle HI/LO path: the ALU decoder issues MULT/MULTU/DIV/DIVU/MTHI/MTLO here.
- Top level stalls the PC while busy is high.
- Radix-2 shift-add multiply and restoring divide; width is generic.

Parameters:
- WIDTH, 32, operand/HI/LO width (>=4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- clk_enable  input  1  global advance enable; low freezes all state
- start  input  1  request; accepted when clk_enable & start & !busy
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
- op_a  input  WIDTH  rs value (multiplicand/dividend/MTHI-MTLO source)
- op_b  input  WIDTH  rt value (multiplier/divisor)
- busy  output  1  iteration in progress
- done  output  1  one-cycle pulse when HI/LO updated by mult/div
- div_by_zero  output  1  sticky flag: last completed divide had op_b==0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (sync, priority over clk_enable): hi=0, lo=0, busy=0, done=0, div_by_zero=0, state IDLE, counter 0. Reset mid-operation aborts it; no partial result is written.
- clk_enable=0: no state changes; counter, busy, hi and lo hold. done also holds, so a pulse stretches until the next enabled edge.
- FSM states: IDLE, MUL, DIV, FIN.
- IDLE:
  - On accept with op 0-3: latch |op_a| and |op_b| (signed ops) or raw (unsigned ops), plus the result-sign bits. Go to MUL or DIV; busy=1 from the next cycle; counter=0.
  - On accept with op 4/5: write hi or lo = op_a at that edge. busy stays 0, done stays 0.
  - op 6/7: ignored.
- MUL: one shift-add step per enabled cycle on a 2*WIDTH accumulator. After WIDTH steps go to FIN.
- DIV: one restoring subtract-shift step per enabled cycle. After WIDTH steps go to FIN.
- FIN (one enabled cycle):
  - Apply sign correction. Product is negated if sign_a^sign_b (signed). Quotient is negated if sign_a^sign_b; remainder takes sign_a.
  - Write {hi,lo} = product, or lo=quotient, hi=remainder.
  - busy=0 and done=1 at the same edge; done clears on the next enabled edge. Return to IDLE.
- Latency: busy is high for exactly WIDTH+1 enabled cycles after the accept edge. A back-to-back start is accepted in the first cycle busy=0.
- Divide by zero:
  - No trap. Result is lo={WIDTH{1}}, hi=op_a (raw), for both DIV and DIVU.
  - Sets div_by_zero at FIN; any later completed divide with nonzero divisor clears it. Multiplies leave it unchanged.
  - Full latency is still taken.
- Signed overflow (most-negative / -1): lo=most-negative, hi=0. This falls out of the abs/negate path naturally.
- start while busy: ignored, including MTHI/MTLO; no queueing.
- hi/lo keep their old values throughout an operation (MFHI during busy reads stale data; the core must stall).

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined:
  - MUL leaves for FIN as soon as the remaining (shifted) multiplier is zero after a step, minimum 1 step. Latency = max(1, bitlen(|op_b|)) + 1 busy cycles.
  - DIV is unchanged.
- Undefined: every multiply takes WIDTH steps. Results are identical either way.

Test Plan:
- MULT op_a=0xFFFFFFFF, op_b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE; busy high 33 cycles; done for 1 cycle. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV -7/2 (0xFFFFFFF9, 2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 7/0 -> lo=0xFFFFFFFF, hi=7, div_by_zero=1. Then DIVU 9/4 -> lo=2, hi=1, div_by_zero=0.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles -> hi=0x1234, lo=0x5678, busy never rises. MTLO 0xAAAA issued during busy -> ignored, lo = mult result.
- During MULTU: clk_enable low 5 cycles -> busy held, total busy 38 cycles, result correct. Assert reset at step 10 -> next cycle hi=lo=0, busy=0, done=0.
- With MULDIV_EARLY_TERM_EN: MULTU 0x10*3 -> busy 3 cycles, lo=0x30. Without the macro: 33 cycles, same result.

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit with HI/LO registers.
// Define MULDIV_EARLY_TERM_EN to let multiplies finish once the multiplier runs out of set bits.
module mips_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               is_div_q, is_div_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               accept;
  logic               signed_op;
  logic               in_sign_a, in_sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   mplier_shr;
  logic               mul_last;
  logic [WIDTH:0]     div_top, div_diff;
  logic [WIDTH-1:0]   rem, quo;
  logic [2*WIDTH-1:0] prod;

  assign accept     = start && (state_q == IDLE);
  assign signed_op  = ~op[0];
  assign in_sign_a  = signed_op & op_a[WIDTH-1];
  assign in_sign_b  = signed_op & op_b[WIDTH-1];
  assign abs_a      = in_sign_a ? -op_a : op_a;
  assign abs_b      = in_sign_b ? -op_b : op_b;
  assign mplier_shr = mplier_q >> 1;
  assign div_top    = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff   = div_top - {1'b0, opb_q[WIDTH-1:0]};
  assign rem        = acc_q[2*WIDTH-1:WIDTH];
  assign quo        = acc_q[WIDTH-1:0];
  assign prod       = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;

`ifdef MULDIV_EARLY_TERM_EN
  assign mul_last = (mplier_shr == '0) || (cnt_q == LAST);
`else
  assign mul_last = (cnt_q == LAST);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else if (clk_enable) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && (op == 3'd0 || op == 3'd1)) state_d = MUL;
        else if (accept && (op == 3'd2 || op == 3'd3)) state_d = DIV;
      end
      MUL:     if (mul_last) state_d = FIN;
      DIV:     if (cnt_q == LAST) state_d = FIN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    done        = done_q;
    div_by_zero = dbz_q;
    hi          = hi_q;
    lo          = lo_q;
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    mplier_d = mplier_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    is_div_d = is_div_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              cnt_d    = '0;
              sign_a_d = in_sign_a;
              sign_b_d = in_sign_b;
              is_div_d = op[1];
              mplier_d = abs_b;
              // Multiply accumulates into a zeroed product; divide seeds {rem, quo} with the dividend.
              acc_d    = op[1] ? {{WIDTH{1'b0}}, abs_a} : '0;
              opb_d    = op[1] ? {{WIDTH{1'b0}}, abs_b} : {{WIDTH{1'b0}}, abs_a};
            end
            3'd4:    hi_d = op_a;
            3'd5:    lo_d = op_a;
            default: ;
          endcase
        end
      end
      MUL: begin
        if (mplier_q[0]) acc_d = acc_q + opb_q;
        opb_d    = opb_q << 1;
        mplier_d = mplier_shr;
        cnt_d    = cnt_q + CNT_W'(1);
      end
      DIV: begin
        if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else                  acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: begin
        done_d = 1'b1;
        cnt_d  = '0;
        if (is_div_q) begin
          // A zero divisor leaves the magnitude of the dividend as remainder; re-sign it to recover raw op_a.
          if (opb_q[WIDTH-1:0] == '0) begin
            lo_d  = '1;
            hi_d  = sign_a_q ? -rem : rem;
            dbz_d = 1'b1;
          end else begin
            lo_d  = (sign_a_q ^ sign_b_q) ? -quo : quo;
            hi_d  = sign_a_q ? -rem : rem;
            dbz_d = 1'b0;
          end
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      mplier_q <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      is_div_q <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (clk_enable) begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      mplier_q <= mplier_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      is_div_q <= is_div_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed scoreboard bench for mips_muldiv_unit (expected HI/LO/latency queued at issue, checked at done).
module tb_mips_muldiv_unit;

  localparam int W = 32;
`ifdef MULDIV_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         clk_enable;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string        tag;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .clk_enable(clk_enable),
    .start(start),
    .op(op),
    .op_a(op_a),
    .op_b(op_b),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .hi(hi),
    .lo(lo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compareValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference latency: full WIDTH steps, or bit length of |op_b| for multiplies with early exit.
  function automatic int expLat(input logic [2:0] o, input logic [W-1:0] b);
    logic [W-1:0] m;
    int bl;
    bit is_mul;
    is_mul = (o == 3'd0) || (o == 3'd1);
    m = (o == 3'd0 && b[W-1]) ? -b : b;
    bl = 0;
    for (int i = 0; i < W; i++) if (m[i]) bl = i + 1;
    if (bl < 1) bl = 1;
    return (EARLY && is_mul) ? bl + 1 : W + 1;
  endfunction

  task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    op_a  = a;
    op_b  = b;
    tick();
    start = 1'b0;
  endtask

  task automatic checkOutput(input int busy_cnt, input int done_early);
    exp_t e;
    if (sb.size() == 0) begin
      $display("[TB] FAIL scoreboard_empty: observed 0 entries required 1");
      miscompares++;
      return;
    end
    e = sb.pop_front();
    compareValue({e.tag, "_busy_cycles"}, 64'(busy_cnt), 64'(e.lat));
    compareValue({e.tag, "_busy_low"}, 64'(busy), 64'(0));
    compareValue({e.tag, "_done"}, 64'(done), 64'(1));
    compareValue({e.tag, "_done_early"}, 64'(done_early), 64'(0));
    compareValue({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
    compareValue({e.tag, "_lo"}, 64'(lo), 64'(e.lo));
    compareValue({e.tag, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
    tick();
    compareValue({e.tag, "_done_pulse"}, 64'(done), 64'(0));
  endtask

  task automatic runOp(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                       input logic [W-1:0] exp_lo, input logic exp_dbz,
                       input int pause_at, input int inj_at);
    exp_t e;
    int busy_cnt;
    int done_early;
    e.tag = tag;
    e.hi  = exp_hi;
    e.lo  = exp_lo;
    e.dbz = exp_dbz;
    e.lat = expLat(o, b) + ((pause_at > 0) ? 5 : 0);
    sb.push_back(e);
    busy_cnt = 0;
    done_early = 0;
    applyStimulus(o, a, b);
    while (busy && busy_cnt < 200) begin
      busy_cnt++;
      if (done) done_early++;
      if (busy_cnt == pause_at) clk_enable = 1'b0;
      if (pause_at > 0 && busy_cnt == pause_at + 5) clk_enable = 1'b1;
      if (busy_cnt == inj_at) begin
        start = 1'b1;
        op    = 3'd5;
        op_a  = 32'h0000_AAAA;
      end
      if (inj_at > 0 && busy_cnt == inj_at + 1) start = 1'b0;
      tick();
    end
    clk_enable = 1'b1;
    start = 1'b0;
    checkOutput(busy_cnt, done_early);
  endtask

  initial begin
    reset      = 1'b1;
    clk_enable = 1'b1;
    start      = 1'b0;
    op         = 3'd0;
    op_a       = '0;
    op_b       = '0;
    repeat (3) tick();
    reset = 1'b0;
    compareValue("reset_hi", 64'(hi), 64'(0));
    compareValue("reset_lo", 64'(lo), 64'(0));
    compareValue("reset_busy", 64'(busy), 64'(0));
    compareValue("reset_done", 64'(done), 64'(0));
    compareValue("reset_dbz", 64'(div_by_zero), 64'(0));

    runOp("mult_m1x2", 3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0, 0);
    runOp("multu_ffx2", 3'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 0, 0);
    runOp("div_m7d2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 0);
    runOp("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 0, 0);
    runOp("divu_7d0", 3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1, 0, 0);
    runOp("divu_9d4", 3'd3, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0, 0, 0);
    runOp("div_m5d0", 3'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 0, 0);
    runOp("multu_keep_dbz", 3'd1, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1, 0, 0);
    runOp("div_100dm7", 3'd2, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0, 0, 0);

    start = 1'b1;
    op    = 3'd4;
    op_a  = 32'h0000_1234;
    tick();
    compareValue("mthi_busy", 64'(busy), 64'(0));
    compareValue("mthi_hi", 64'(hi), 64'h1234);
    op   = 3'd5;
    op_a = 32'h0000_5678;
    tick();
    start = 1'b0;
    compareValue("mtlo_busy", 64'(busy), 64'(0));
    compareValue("mtlo_done", 64'(done), 64'(0));
    compareValue("mtlo_hi", 64'(hi), 64'h1234);
    compareValue("mtlo_lo", 64'(lo), 64'h5678);

    runOp("multu_mtlo_ignored", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 0, 3);
    runOp("multu_10x3", 3'd1, 32'h10, 32'd3, 32'd0, 32'h30, 1'b0, 0, 0);
    runOp("multu_pause", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, 10, 0);
    runOp("divu_7d0_again", 3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1, 0, 0);

    // Reset in the middle of a multiply must discard it and clear everything.
    applyStimulus(3'd1, 32'h0000_1234, 32'h0000_5678);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    compareValue("midreset_hi", 64'(hi), 64'(0));
    compareValue("midreset_lo", 64'(lo), 64'(0));
    compareValue("midreset_busy", 64'(busy), 64'(0));
    compareValue("midreset_done", 64'(done), 64'(0));
    compareValue("midreset_dbz", 64'(div_by_zero), 64'(0));
    repeat (40) tick();
    compareValue("postreset_busy", 64'(busy), 64'(0));
    compareValue("postreset_lo", 64'(lo), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
